// File: rtl/period_meter.sv
// period_meter: measures the rising-edge-to-rising-edge period of an asynchronous input in clk_in cycles.
// Optional macro PERIOD_METER_HIGH_EN adds a high-time measurement on high_out (tied to 0 otherwise).
module period_meter #(
  parameter int              SIZE    = 26,
  parameter logic [SIZE-1:0] TIMEOUT = 26'd50000000
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            sig_in,
  output logic [SIZE-1:0] period_out,
  output logic            period_valid,
  output logic            timeout,
  output logic [SIZE-1:0] high_out
);

  typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

  localparam logic [SIZE-1:0] LP_LAST = TIMEOUT - 1'b1;

  state_t          r_state;
  logic            r_s1, r_s2, r_s3;
  logic [SIZE-1:0] r_count;
  logic            w_rise;

  // Every edge sees the same synchroniser delay, so edge-to-edge spacing is preserved exactly.
  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_state      <= ST_IDLE;
      r_count      <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_s1         <= sig_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      period_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          if (w_rise) begin
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // A rise on the final allowed cycle still counts as a measurement of TIMEOUT.
          if (w_rise) begin
            period_out   <= r_count + 1'b1;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
            r_count      <= '0;
          end else if (r_count == LP_LAST) begin
            timeout <= 1'b1;
            r_count <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_HIGH_EN
  logic [SIZE-1:0] r_hcount;

  // The rise cycle itself has s2 high, so a fresh measurement restarts the high count at 1.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      high_out <= '0;
    end else if (w_rise) begin
      r_hcount <= {{(SIZE-1){1'b0}}, 1'b1};
      if (r_state == ST_MEASURE) begin
        high_out <= r_hcount;
      end
    end else if (r_state == ST_MEASURE) begin
      r_hcount <= r_hcount + {{(SIZE-1){1'b0}}, r_s2};
    end
  end
`else
  assign high_out = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized and directed stimulus for period_meter, checked every cycle
// against an edge-timestamp model of the measurement rules.
module tb_period_meter;

  localparam int SIZE    = 8;
  localparam int TIMEOUT = 200;
  localparam int MAXCYC  = 20000;

  logic            clk_in = 1'b0;
  logic            rst_n  = 1'b0;
  logic            sig_in = 1'b0;
  logic [SIZE-1:0] period_out;
  logic            period_valid;
  logic            timeout;
  logic [SIZE-1:0] high_out;

  int vectors     = 0;
  int miscompares = 0;

  int sampled [0:MAXCYC-1];
  int cyc      = 0;
  bit armed    = 1'b0;
  int lastRise = 0;
  int expPeriod = 0;
  int expHigh   = 0;
  bit expValid   = 1'b0;
  bit expTimeout = 1'b0;

  int dutLastPeriod = 0;
  int dutLastHigh   = 0;

  period_meter #(.SIZE(SIZE), .TIMEOUT(8'd200)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .timeout     (timeout),
    .high_out    (high_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Drive one period of the input: high for hi cycles, then low for lo cycles.
  task automatic applyStimulus(input int hi, input int lo);
    repeat (hi) begin
      @(negedge clk_in);
      sig_in = 1'b1;
    end
    repeat (lo) begin
      @(negedge clk_in);
      sig_in = 1'b0;
    end
  endtask

  // Reference model: timestamps every input sample, finds rising edges two samples back,
  // and derives period, high time and timeout from the gaps between those edges.
  always @(posedge clk_in) begin
    bit rise;
    int acc;
    cyc++;
    if (cyc >= MAXCYC) begin
      $display("[TB] FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXCYC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    expValid = 1'b0;
    if (!rst_n) begin
      sampled[cyc] = 0;
      armed      = 1'b0;
      expPeriod  = 0;
      expHigh    = 0;
      expTimeout = 1'b0;
    end else begin
      sampled[cyc] = int'(sig_in);
      rise = (cyc >= 3) && (sampled[cyc-2] == 1) && (sampled[cyc-3] == 0);
      if (rise) begin
        if (armed) begin
          expPeriod  = cyc - lastRise;
          expValid   = 1'b1;
          expTimeout = 1'b0;
          acc = 0;
`ifdef PERIOD_METER_HIGH_EN
          for (int j = lastRise; j < cyc; j++) acc += sampled[j-2];
`endif
          expHigh = acc;
        end
        armed    = 1'b1;
        lastRise = cyc;
      end else if (armed && (cyc - lastRise == TIMEOUT)) begin
        expTimeout = 1'b1;
        armed      = 1'b0;
      end
    end
    #1;
    checkOutput("period_valid", int'(period_valid), int'(expValid));
    checkOutput("timeout", int'(timeout), int'(expTimeout));
    checkOutput("period_out", int'(period_out), expPeriod);
    checkOutput("high_out", int'(high_out), expHigh);
    if (period_valid) begin
      dutLastPeriod = int'(period_out);
      dutLastHigh   = int'(high_out);
    end
  end

  // Main stimulus sequence: directed scenarios first, then random periods and duty cycles.
  initial begin
    int p;
    int hi;
    $display("[TB] period_meter bench start");
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (5) applyStimulus(2, 2);
    checkOutput("rst_period_out", int'(period_out), 0);
    checkOutput("rst_valid", int'(period_valid), 0);
    checkOutput("rst_timeout", int'(timeout), 0);
    checkOutput("rst_high_out", int'(high_out), 0);

    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (8) applyStimulus(5, 5);
    checkOutput("p10_dut", dutLastPeriod, 10);
    checkOutput("p10_model", expPeriod, 10);

    repeat (5) applyStimulus(18, 19);
    checkOutput("p37_dut", dutLastPeriod, 37);

    applyStimulus(5, 250);
    checkOutput("hold_timeout_dut", int'(timeout), 1);
    checkOutput("hold_timeout_model", int'(expTimeout), 1);
    repeat (3) applyStimulus(5, 5);
    checkOutput("rearm_p10_dut", dutLastPeriod, 10);
    checkOutput("rearm_timeout_dut", int'(timeout), 0);

    repeat (3) applyStimulus(100, 100);
    checkOutput("p200_dut", dutLastPeriod, 200);
    checkOutput("p200_timeout_dut", int'(timeout), 0);

    applyStimulus(3, 20);
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_period_out", int'(period_out), 0);
    checkOutput("midrst_timeout", int'(timeout), 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) applyStimulus(3, 7);
    checkOutput("duty_p10_dut", dutLastPeriod, 10);
`ifdef PERIOD_METER_HIGH_EN
    checkOutput("duty_high3_dut", dutLastHigh, 3);
`else
    checkOutput("duty_high0_dut", dutLastHigh, 0);
`endif

    repeat (30) begin
      p  = int'($urandom_range(250, 2));
      hi = int'($urandom_range(p - 1, 1));
      applyStimulus(hi, p - hi);
    end

    repeat (5) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
